corner_overlay: RTL and testbench
=================================

Name: corner_overlay

Overview:
- Consumes the delayed sync/vde stream from the sync-delay stage, together with the aligned pixel and the corner flag from the 15x15 detector window.
- Tracks the active-area x/y position and paints a horizontal marker stripe over each detected corner.
- Publishes a per-frame corner count to the SLAM control side.
- Sits directly downstream of the sync-delay stage and upstream of the HDMI encoder.

Parameters:
- H_ACTIVE, 1280, active pixels per line; sizes the x counter.
- V_ACTIVE, 720, active lines per frame; sizes the y counter.
- MARK_W, 5, marker stripe length in active pixels (>=1).
- MARK_COLOR, 24'hFF0000, RGB888 colour painted on the stripe.
- CNT_W, 16, corner counter width.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hsync_in  in  1  delayed hsync, active-high
- vsync_in  in  1  delayed vsync, active-high
- vde_in  in  1  delayed video-data-enable
- pix_in  in  24  RGB888 pixel aligned with vde_in
- corner_in  in  1  corner flag for the current pixel, qualified by vde_in
- overlay_en  in  1  1 = paint markers, 0 = pass pixels through unchanged
- hsync_out  out  1  hsync_in delayed by 1 cycle
- vsync_out  out  1  vsync_in delayed by 1 cycle
- vde_out  out  1  vde_in delayed by 1 cycle
- pix_out  out  24  pixel after overlay, 1-cycle latency
- x_pos  out  $clog2(H_ACTIVE)  active column of pix_out
- y_pos  out  $clog2(V_ACTIVE)  active row of pix_out
- corner_count  out  CNT_W  corners counted in the last complete frame
- count_valid  out  1  1-cycle pulse when corner_count updates

Behaviour:
- Reset (async assert, sync release): all outputs 0; internal x/y/stripe/running counters 0; vsync_d/vde_d edge registers 0; locked = 0.
- Latency: every stream output (syncs, vde, pix, x_pos, y_pos) is exactly 1 registered cycle after its input; no combinational path from inputs to outputs.
- x counter:
  - Loads 0 on a vde rising edge (vde_in=1, vde_d=0).
  - Increments on each further vde_in=1 cycle.
  - Saturates at H_ACTIVE-1.
- y counter:
  - Increments on each vde falling edge, saturating at V_ACTIVE-1.
  - Clears to 0 on a vsync rising edge.
- Stripe (MARK_W-bit length counter `stripe`):
  - Paint condition: (corner_in & vde_in) | (stripe!=0 & vde_in).
  - When corner_in & vde_in: the current pixel is painted and stripe loads MARK_W-1.
  - Otherwise, if stripe!=0 & vde_in: the pixel is painted and stripe decrements.
  - A new corner inside an active stripe reloads it; stripes never extend past their own MARK_W count.
  - vde_in=0 clears stripe, so a stripe never carries across a line end.
  - pix_out = MARK_COLOR when paint & overlay_en, else pix_in; pix_out = 0 when vde_in=0.
  - corner_in with vde_in=0 is ignored (no paint, no count).
- Corner counting:
  - The running count increments on each corner_in & vde_in cycle and saturates at 2^CNT_W-1.
  - On a vsync rising edge: if locked, corner_count <= running count (including a qualified corner on that same cycle) and count_valid pulses for 1 cycle. Then the running count <= 0 and locked <= 1.
  - The first vsync edge after reset only sets locked, so a partial frame is never published.
- overlay_en affects painting only. Counting and x/y tracking are unaffected.
- Mid-frame reset: outputs drop to 0 immediately. After release, the block waits for the next vsync edge before its y count is meaningful; one more vsync edge is needed before count_valid can pulse.
- Continuous vsync high (>1 cycle) produces one edge only; hsync is pass-through and does not affect counters.

Test Plan:
1. 1280x720 timing, overlay_en=1, single corner_in at x=100, y=10 -> pix_out=FF0000 at x=100..104 on line 10 (1 cycle later), all other pixels equal pix_in; x_pos/y_pos match.
2. Corner at x=1278 -> painted only x=1278,1279; x=0 of line 11 unpainted.
3. Corners at x=200 and x=203 -> painted x=200..207; running count +2.
4. Frame 1 partial after reset with 7 corners, frame 2 with 3 corners, frame 3 with 0 -> no count_valid at first vsync edge; count_valid with corner_count=3 at second edge; corner_count=0 at third.
5. CNT_W=4, 20 corners in a frame -> corner_count=15; overlay_en=0 -> pix_out==pix_in bit-exact, count unaffected.
6. rst_n asserted at mid-line during a stripe -> all outputs 0 same cycle; after release no paint until the next corner_in; corner_in with vde_in=0 -> no paint, no count.

Source files
------------

// File: rtl/corner_overlay.sv
// corner_overlay: tracks the active-area x/y position of the delayed video stream,
// paints a fixed-length marker stripe from each detected corner and publishes a per-frame corner count.
module corner_overlay #(
  parameter int          H_ACTIVE   = 1280,
  parameter int          V_ACTIVE   = 720,
  parameter int          MARK_W     = 5,
  parameter logic [23:0] MARK_COLOR = 24'hFF0000,
  parameter int          CNT_W      = 16,
  localparam int         XW         = $clog2(H_ACTIVE),
  localparam int         YW         = $clog2(V_ACTIVE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             vde_in,
  input  logic [23:0]      pix_in,
  input  logic             corner_in,
  input  logic             overlay_en,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             vde_out,
  output logic [23:0]      pix_out,
  output logic [XW-1:0]    x_pos,
  output logic [YW-1:0]    y_pos,
  output logic [CNT_W-1:0] corner_count,
  output logic             count_valid
);

  localparam logic [XW-1:0]     X_MAX  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]     Y_MAX  = YW'(V_ACTIVE - 1);
  localparam logic [MARK_W-1:0] S_LOAD = MARK_W'(MARK_W - 1);
  localparam logic [CNT_W-1:0]  C_MAX  = '1;

  logic              hsync_q, vsync_q, vde_q;
  logic [23:0]       pix_q, pix_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [MARK_W-1:0] stripe_q, stripe_d;
  logic [CNT_W-1:0]  run_q, run_d, run_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cvalid_q, cvalid_d;
  logic              locked_q, locked_d;

  logic vde_rise, vde_fall, vs_rise, corner_hit, paint;

  // The registered sync/vde copies double as the edge-detect history.
  assign vde_rise   = vde_in & ~vde_q;
  assign vde_fall   = ~vde_in & vde_q;
  assign vs_rise    = vsync_in & ~vsync_q;
  assign corner_hit = corner_in & vde_in;
  assign paint      = vde_in & (corner_in | (stripe_q != '0));

  always_comb begin
    stripe_d = '0;
    if (vde_in) begin
      if (corner_in)              stripe_d = S_LOAD;
      else if (stripe_q != '0)    stripe_d = stripe_q - MARK_W'(1);
    end

    pix_d = '0;
    if (vde_in) pix_d = (paint && overlay_en) ? MARK_COLOR : pix_in;

    x_d = x_q;
    if (vde_rise)                   x_d = '0;
    else if (vde_in && x_q != X_MAX) x_d = x_q + XW'(1);

    y_d = y_q;
    if (vs_rise)                      y_d = '0;
    else if (vde_fall && y_q != Y_MAX) y_d = y_q + YW'(1);

    // A qualified corner on the vsync-edge cycle still belongs to the closing frame.
    run_inc  = (corner_hit && run_q != C_MAX) ? run_q + CNT_W'(1) : run_q;
    run_d    = vs_rise ? '0 : run_inc;
    cnt_d    = (vs_rise && locked_q) ? run_inc : cnt_q;
    cvalid_d = vs_rise & locked_q;
    locked_d = locked_q | vs_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vde_q    <= 1'b0;
      pix_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      stripe_q <= '0;
      run_q    <= '0;
      cnt_q    <= '0;
      cvalid_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      hsync_q  <= hsync_in;
      vsync_q  <= vsync_in;
      vde_q    <= vde_in;
      pix_q    <= pix_d;
      x_q      <= x_d;
      y_q      <= y_d;
      stripe_q <= stripe_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      cvalid_q <= cvalid_d;
      locked_q <= locked_d;
    end
  end

  assign hsync_out    = hsync_q;
  assign vsync_out    = vsync_q;
  assign vde_out      = vde_q;
  assign pix_out      = pix_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign corner_count = cnt_q;
  assign count_valid  = cvalid_q;

endmodule

// File: tb/tb_corner_overlay.sv
// Bench for corner_overlay on a reduced raster; expected pixels come from a
// "any corner within the last MARK_W pixels of this line" rule, counts from per-frame tallies.
module tb_corner_overlay;
  localparam int H  = 32;
  localparam int V  = 12;
  localparam int MW = 5;
  localparam int CW = 4;
  localparam logic [23:0] COL = 24'hFF0000;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hsync_in = 1'b0, vsync_in = 1'b0, vde_in = 1'b0, corner_in = 1'b0;
  logic          overlay_en = 1'b1;
  logic [23:0]   pix_in = '0;
  logic          hsync_out, vsync_out, vde_out, count_valid;
  logic [23:0]   pix_out;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic [CW-1:0] corner_count;

  corner_overlay #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MARK_W(MW), .MARK_COLOR(COL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vde_in(vde_in), .pix_in(pix_in), .corner_in(corner_in), .overlay_en(overlay_en),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .vde_out(vde_out), .pix_out(pix_out),
    .x_pos(x_pos), .y_pos(y_pos), .corner_count(corner_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: line index since vsync, lock flag, corners this frame, published count.
  int m_y = 0;
  bit m_locked = 0;
  int m_frame = 0;
  int m_count = 0;
  bit cm [0:63];

  function automatic void clear_cm();
    for (int i = 0; i < 64; i++) cm[i] = 0;
  endfunction

  // One active line of len pixels using the corner map cm, then three blanking cycles.
  task automatic drive_line(input int len);
    logic [23:0] px, exp;
    bit hit;
    for (int i = 0; i < len; i++) begin
      px = 24'($urandom);
      pix_in = px; vde_in = 1'b1; corner_in = cm[i]; hsync_in = 1'b0; vsync_in = 1'b0;
      @(posedge clk); #1;
      hit = 0;
      for (int j = i - MW + 1; j <= i; j++) if (j >= 0 && cm[j]) hit = 1;
      if (cm[i]) m_frame++;
      exp = (hit && overlay_en) ? COL : px;
      checks++;
      if (pix_out !== exp || vde_out !== 1'b1 || x_pos !== XW'(i < H-1 ? i : H-1) || y_pos !== YW'(m_y)) begin
        errors++;
        $display("FAIL active_px y=%0d i=%0d got pix=%h x=%0d y=%0d vde=%b want pix=%h x=%0d y=%0d",
                 m_y, i, pix_out, x_pos, y_pos, vde_out, exp, (i < H-1 ? i : H-1), m_y);
      end
    end
    for (int k = 0; k < 3; k++) begin
      vde_in = 1'b0; hsync_in = (k == 1); corner_in = 1'($urandom); pix_in = 24'($urandom);
      @(posedge clk); #1;
      if (k == 0 && m_y < V-1) m_y++;
      checks++;
      if (pix_out !== 24'h0 || vde_out !== 1'b0 || hsync_out !== hsync_in || y_pos !== YW'(m_y) || count_valid !== 1'b0) begin
        errors++;
        $display("FAIL blank k=%0d got pix=%h vde=%b hs=%b y=%0d cv=%b want pix=0 vde=0 hs=%b y=%0d cv=0",
                 k, pix_out, vde_out, hsync_out, y_pos, count_valid, hsync_in, m_y);
      end
    end
  endtask

  task automatic vsync_pulse(input int len);
    bit ev;
    for (int k = 0; k < len; k++) begin
      vsync_in = 1'b1; vde_in = 1'b0; hsync_in = 1'b0;
      corner_in = 1'($urandom); pix_in = 24'($urandom);
      @(posedge clk); #1;
      ev = 0;
      if (k == 0) begin
        ev = m_locked;
        if (m_locked) m_count = (m_frame > (1 << CW) - 1) ? (1 << CW) - 1 : m_frame;
        m_frame = 0; m_locked = 1; m_y = 0;
      end
      checks++;
      if (count_valid !== ev || corner_count !== CW'(m_count) || vsync_out !== 1'b1 || y_pos !== '0 || pix_out !== 24'h0) begin
        errors++;
        $display("FAIL vsync k=%0d got cv=%b cnt=%0d vs=%b y=%0d want cv=%b cnt=%0d vs=1 y=0",
                 k, count_valid, corner_count, vsync_out, y_pos, ev, m_count);
      end
    end
    for (int k = 0; k < 2; k++) begin
      vsync_in = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (count_valid !== 1'b0 || vsync_out !== 1'b0 || corner_count !== CW'(m_count)) begin
        errors++;
        $display("FAIL vsync_tail got cv=%b vs=%b cnt=%0d want cv=0 vs=0 cnt=%0d",
                 count_valid, vsync_out, corner_count, m_count);
      end
    end
  endtask

  task automatic random_frame(input int nlines, input int one_in);
    for (int l = 0; l < nlines; l++) begin
      clear_cm();
      for (int i = 0; i < H; i++) cm[i] = ($urandom_range(0, one_in - 1) == 0);
      drive_line(H);
    end
  endtask

  task automatic test_reset();
    vde_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; corner_in = 1'b1; pix_in = 24'($urandom);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hsync_out, vsync_out, vde_out, pix_out, x_pos, y_pos, corner_count, count_valid} !== '0) begin
      errors++;
      $display("FAIL reset_state got hs=%b vs=%b vde=%b pix=%h x=%0d y=%0d cnt=%0d cv=%b want all 0",
               hsync_out, vsync_out, vde_out, pix_out, x_pos, y_pos, corner_count, count_valid);
    end
    vde_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; corner_in = 1'b0;
    rst_n = 1'b1;
  endtask

  // Corners before the first vsync must never be published.
  task automatic test_partial_frame();
    for (int l = 0; l < 4; l++) begin
      clear_cm();
      case (l)
        0: begin cm[2] = 1; cm[20] = 1; end
        1: begin cm[5] = 1; cm[6] = 1; cm[7] = 1; end
        2: cm[H-2] = 1;
        default: cm[0] = 1;
      endcase
      drive_line(H);
    end
    vsync_pulse(2);
  endtask

  task automatic test_single_corner();
    for (int l = 0; l < V; l++) begin
      clear_cm();
      if (l == 10) cm[10] = 1;
      drive_line(H);
    end
    vsync_pulse(1);
  endtask

  task automatic test_line_end();
    for (int l = 0; l < V; l++) begin
      clear_cm();
      if (l == 5) cm[H-2] = 1;
      drive_line(H);
    end
    vsync_pulse(1);
  endtask

  task automatic test_reload();
    for (int l = 0; l < V; l++) begin
      clear_cm();
      if (l == 2) begin cm[10] = 1; cm[13] = 1; end
      if (l == 7) cm[4] = 1;
      drive_line(H);
    end
    vsync_pulse(1);
  endtask

  task automatic test_zero_frame();
    random_frame(V, 1000000);
    vsync_pulse(3);
  endtask

  // 20 corners, lines past V_ACTIVE and pixels past H_ACTIVE exercise every saturation.
  task automatic test_saturate();
    for (int l = 0; l < V + 2; l++) begin
      clear_cm();
      if (l < 2) for (int i = 0; i < 10; i++) cm[3*i + l] = 1;
      drive_line(H + 3);
    end
    vsync_pulse(4);
  endtask

  task automatic test_overlay_off();
    overlay_en = 1'b0;
    random_frame(V, 6);
    vsync_pulse(1);
    overlay_en = 1'b1;
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      overlay_en = 1'($urandom);
      random_frame(V, 12);
      vsync_pulse(1 + $urandom_range(0, 2));
    end
    overlay_en = 1'b1;
  endtask

  task automatic test_midreset();
    clear_cm();
    cm[4] = 1;
    for (int i = 0; i < 7; i++) begin
      pix_in = 24'($urandom); vde_in = 1'b1; corner_in = cm[i]; hsync_in = (i > 5);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hsync_out, vsync_out, vde_out, pix_out, x_pos, y_pos, corner_count, count_valid} !== '0) begin
      errors++;
      $display("FAIL midreset got hs=%b vs=%b vde=%b pix=%h x=%0d y=%0d cnt=%0d cv=%b want all 0",
               hsync_out, vsync_out, vde_out, pix_out, x_pos, y_pos, corner_count, count_valid);
    end
    vde_in = 1'b0; corner_in = 1'b0; hsync_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_y = 0; m_locked = 0; m_frame = 0; m_count = 0;
    clear_cm();
    drive_line(H);
    cm[20] = 1;
    drive_line(H);
    vsync_pulse(1);
    clear_cm();
    cm[1] = 1; cm[25] = 1;
    drive_line(H);
    vsync_pulse(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clear_cm();
    test_reset();
    test_partial_frame();
    test_single_corner();
    test_line_end();
    test_reload();
    test_zero_frame();
    test_saturate();
    test_overlay_off();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
